udp_audio_sched: RTL and testbench

Packet scheduler between the two WM8731 capture paths and the UDP transmit port of the Ethernet core. Buffers 16-bit samples from two audio channels in per-channel FIFOs. When a channel has a full packet, it arbitrates round-robin and streams one framed UDP payload byte-by-byte over the core's valid/ready send interface. It sits between the `mywav` record outputs (or the adaptive-filter error output) and `ethernet_test`.

---
 rtl/udp_audio_sched.sv | 194 +++++++++++++++++++
 tb/tb_udp_audio_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/udp_audio_sched.sv
// Two-channel audio sample buffer and round-robin UDP packet scheduler.
// Streams framed packets {ch id, seq, samples hi/lo} over a valid/ready byte port.
module udp_audio_sched #(
  parameter int unsigned PKT_SAMPLES = 128,
  parameter int unsigned FIFO_DEPTH  = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ch0_data,
  input  logic        ch0_valid,
  input  logic [15:0] ch1_data,
  input  logic        ch1_valid,
  output logic        udp_send_data_valid,
  input  logic        udp_send_data_ready,
  output logic [7:0]  udp_send_data,
  output logic [15:0] udp_send_data_length,
  output logic        busy,
  output logic        grant_ch,
  output logic [1:0]  ovf,
  output logic [15:0] drop_cnt0,
  output logic [15:0] drop_cnt1
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned SCW = $clog2(PKT_SAMPLES + 1);
  localparam logic [SCW-1:0] LastSample = SCW'(PKT_SAMPLES - 1);

  typedef enum logic [2:0] {StIdle, StHdrCh, StHdrSeq, StDHi, StDLo} state_e;

  state_e state_q, state_d;

  logic [1:0][15:0] wr_data;
  logic [1:0]       wr_vld;
  logic [1:0]       push, pop, full, elig;

  logic [15:0] mem_q [2][FIFO_DEPTH];

  logic [1:0][AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0][15:0]   drop_q, drop_d;
  logic [1:0]         ovf_q, ovf_d;
  logic [1:0][7:0]    seq_q, seq_d;

  logic           valid_q, valid_d;
  logic [7:0]     data_q, data_d;
  logic           busy_q, busy_d;
  logic           gnt_q, gnt_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic           hs;
  logic [AW-1:0]  head_ptr, next_ptr;
  logic [15:0]    head, next_head;

  assign wr_data = {ch1_data, ch0_data};
  assign wr_vld  = {ch1_valid, ch0_valid};
  assign hs      = valid_q && udp_send_data_ready;

  // Only the granted channel is ever popped, at the low-byte handshake.
  assign pop[0] = hs && (state_q == StDLo) && !gnt_q;
  assign pop[1] = hs && (state_q == StDLo) && gnt_q;

  assign head_ptr  = rd_ptr_q[gnt_q];
  assign next_ptr  = head_ptr + AW'(1);
  assign head      = mem_q[gnt_q][head_ptr];
  assign next_head = mem_q[gnt_q][next_ptr];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    full     = '0;
    elig     = '0;
    push     = '0;
    for (int n = 0; n < 2; n++) begin
      full[n] = (cnt_q[n] == CW'(FIFO_DEPTH));
      elig[n] = (cnt_q[n] >= CW'(PKT_SAMPLES));
      // At full a write only fits if a pop frees a slot in the same cycle.
      push[n] = wr_vld[n] && (!full[n] || pop[n]);
      if (wr_vld[n] && !push[n]) begin
        ovf_d[n] = 1'b1;
        if (drop_q[n] != 16'hFFFF) drop_d[n] = drop_q[n] + 16'd1;
      end
      if (push[n]) wr_ptr_d[n] = wr_ptr_q[n] + AW'(1);
      if (pop[n])  rd_ptr_d[n] = rd_ptr_q[n] + AW'(1);
      if (push[n] && !pop[n])      cnt_d[n] = cnt_q[n] + CW'(1);
      else if (pop[n] && !push[n]) cnt_d[n] = cnt_q[n] - CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    busy_d  = busy_q;
    gnt_d   = gnt_q;
    scnt_d  = scnt_q;
    seq_d   = seq_q;
    unique case (state_q)
      StIdle: begin
        if (elig[0] || elig[1]) begin
          gnt_d   = (elig[0] && elig[1]) ? ~gnt_q : elig[1];
          state_d = StHdrCh;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          data_d  = {7'b0, gnt_d};
          scnt_d  = '0;
        end
      end
      StHdrCh: begin
        if (hs) begin
          state_d = StHdrSeq;
          data_d  = seq_q[gnt_q];
        end
      end
      StHdrSeq: begin
        if (hs) begin
          state_d = StDHi;
          data_d  = head[15:8];
        end
      end
      StDHi: begin
        if (hs) begin
          state_d = StDLo;
          data_d  = head[7:0];
        end
      end
      StDLo: begin
        if (hs) begin
          if (scnt_q == LastSample) begin
            state_d       = StIdle;
            valid_d       = 1'b0;
            busy_d        = 1'b0;
            data_d        = 8'h00;
            seq_d[gnt_q]  = seq_q[gnt_q] + 8'd1;
          end else begin
            state_d = StDHi;
            scnt_d  = scnt_q + SCW'(1);
            data_d  = next_head[15:8];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sample storage has no reset; discarding is done by clearing the pointers.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) mem_q[n][wr_ptr_q[n]] <= wr_data[n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= '0;
      seq_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
      busy_q   <= 1'b0;
      gnt_q    <= 1'b1;
      scnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      seq_q    <= seq_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      gnt_q    <= gnt_d;
      scnt_q   <= scnt_d;
    end
  end

  assign udp_send_data_valid  = valid_q;
  assign udp_send_data        = data_q;
  assign udp_send_data_length = 16'(2 + 2 * PKT_SAMPLES);
  assign busy                 = busy_q;
  assign grant_ch             = gnt_q;
  assign ovf                  = ovf_q;
  assign drop_cnt0            = drop_q[0];
  assign drop_cnt1            = drop_q[1];

endmodule

// File: tb/tb_udp_audio_sched.sv
// Directed bench for udp_audio_sched: packet vector table plus overflow, seq wrap
// and mid-packet reset sequences, run with a reduced packet size.
module tb_udp_audio_sched;

  localparam int unsigned P    = 8;
  localparam int unsigned D    = 16;
  localparam int unsigned PLEN = 2 + 2 * P;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ch0_data, ch1_data;
  logic        ch0_valid, ch1_valid;
  logic        udp_send_data_valid;
  logic        udp_send_data_ready;
  logic [7:0]  udp_send_data;
  logic [15:0] udp_send_data_length;
  logic        busy, grant_ch;
  logic [1:0]  ovf;
  logic [15:0] drop_cnt0, drop_cnt1;

  int n_vec = 0;
  int n_err = 0;

  udp_audio_sched #(.PKT_SAMPLES(P), .FIFO_DEPTH(D)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ch0_data             (ch0_data),
    .ch0_valid            (ch0_valid),
    .ch1_data             (ch1_data),
    .ch1_valid            (ch1_valid),
    .udp_send_data_valid  (udp_send_data_valid),
    .udp_send_data_ready  (udp_send_data_ready),
    .udp_send_data        (udp_send_data),
    .udp_send_data_length (udp_send_data_length),
    .busy                 (busy),
    .grant_ch             (grant_ch),
    .ovf                  (ovf),
    .drop_cnt0            (drop_cnt0),
    .drop_cnt1            (drop_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mask;
    logic [15:0] b0;
    logic [15:0] b1;
    bit          rnd;
    int          npk;
    logic        ch_a;
    logic [7:0]  seq_a;
    logic        ch_b;
    logic [7:0]  seq_b;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr_burst(input logic [1:0] mask, input logic [15:0] b0, input logic [15:0] b1,
                          input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ch0_valid = mask[0];
      ch0_data  = b0 + 16'(i);
      ch1_valid = mask[1];
      ch1_data  = b1 + 16'(i);
    end
    @(negedge clk);
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
  endtask

  // Receives one packet and checks every byte against the expected framing.
  task automatic rx_pkt(input logic ch, input logic [7:0] seq, input logic [15:0] base,
                        input bit rnd);
    int          idx    = 0;
    int          idle_n = 0;
    bit          stall  = 1'b0;
    logic [7:0]  pd     = 8'h00;
    logic [7:0]  exp;
    logic [15:0] smp;
    while (idx < int'(PLEN)) begin
      @(negedge clk);
      if (stall) chk("stall_data", {23'b0, udp_send_data_valid, udp_send_data}, {24'h1, pd});
      stall = 1'b0;
      if (udp_send_data_valid) begin
        idle_n = 0;
        udp_send_data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (udp_send_data_ready) begin
          if (idx == 0) begin
            exp = {7'b0, ch};
            chk("grant_ch", {31'b0, grant_ch}, {31'b0, ch});
            chk("busy_in_pkt", {31'b0, busy}, 32'd1);
          end else if (idx == 1) begin
            exp = seq;
          end else begin
            smp = base + 16'((idx - 2) / 2);
            exp = (idx % 2 == 0) ? smp[15:8] : smp[7:0];
          end
          chk($sformatf("byte%0d", idx), {24'b0, udp_send_data}, {24'b0, exp});
          idx++;
        end else begin
          stall = 1'b1;
          pd    = udp_send_data;
        end
      end else begin
        udp_send_data_ready = 1'b0;
        idle_n++;
        if (idle_n > 300) begin
          chk("rx_timeout", 32'd0, 32'd1);
          return;
        end
      end
    end
    @(negedge clk);
    udp_send_data_ready = 1'b0;
    chk("post_pkt_idle", {30'b0, udp_send_data_valid, busy}, 32'd0);
  endtask

  task automatic expect_quiet(input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (udp_send_data_valid) seen++;
    end
    chk("quiet_valid_cycles", 32'(seen), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_n;
    vecs[0] = '{2'b11, 16'h0000, 16'h8000, 1'b0, 2, 1'b0, 8'd0, 1'b1, 8'd0};
    vecs[1] = '{2'b11, 16'h1234, 16'hFF00, 1'b0, 2, 1'b0, 8'd1, 1'b1, 8'd1};
    vecs[2] = '{2'b01, 16'h7FF8, 16'h0000, 1'b1, 1, 1'b0, 8'd2, 1'b0, 8'd0};
    vecs[3] = '{2'b10, 16'h0000, 16'h8001, 1'b1, 1, 1'b1, 8'd2, 1'b0, 8'd0};

    rst_n = 1'b0;
    ch0_data = '0; ch1_data = '0; ch0_valid = 1'b0; ch1_valid = 1'b0;
    udp_send_data_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", {31'b0, udp_send_data_valid}, 32'd0);
    chk("rst_data", {24'b0, udp_send_data}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_grant", {31'b0, grant_ch}, 32'd1);
    chk("rst_ovf_drop", {14'b0, ovf, drop_cnt0}, 32'd0);
    chk("rst_drop1", {16'b0, drop_cnt1}, 32'd0);
    chk("length", {16'b0, udp_send_data_length}, 32'(PLEN));

    for (int v = 0; v < 4; v++) begin
      wr_burst(vecs[v].mask, vecs[v].b0, vecs[v].b1, int'(P));
      rx_pkt(vecs[v].ch_a, vecs[v].seq_a, vecs[v].ch_a ? vecs[v].b1 : vecs[v].b0, vecs[v].rnd);
      if (vecs[v].npk > 1)
        rx_pkt(vecs[v].ch_b, vecs[v].seq_b, vecs[v].ch_b ? vecs[v].b1 : vecs[v].b0,
               vecs[v].rnd);
      expect_quiet(10);
    end

    // Overflow: ready held low, D+3 writes to ch1 leaves a full FIFO and 3 drops.
    wr_burst(2'b10, 16'h0000, 16'h4000, int'(D) + 3);
    @(negedge clk);
    chk("ovf", {30'b0, ovf}, 32'd2);
    chk("drop_cnt1", {16'b0, drop_cnt1}, 32'd3);
    chk("drop_cnt0", {16'b0, drop_cnt0}, 32'd0);
    chk("stalled_hdr", {23'b0, udp_send_data_valid, udp_send_data}, 32'h101);
    rx_pkt(1'b1, 8'd3, 16'h4000, 1'b0);
    rx_pkt(1'b1, 8'd4, 16'h4000 + 16'(P), 1'b0);
    expect_quiet(30);

    // Sequence wrap on ch0: starts at 3, reaches 0xFF then 0x00.
    for (int k = 0; k < 254; k++) begin
      wr_burst(2'b01, 16'(k * 16), 16'h0000, int'(P));
      rx_pkt(1'b0, 8'(3 + k), 16'(k * 16), 1'b0);
    end

    // Mid-packet asynchronous reset.
    wr_burst(2'b01, 16'hABC0, 16'h0000, int'(P));
    hs_n = 0;
    for (int c = 0; c < 300 && hs_n < 10; c++) begin
      @(negedge clk);
      udp_send_data_ready = 1'b1;
      if (udp_send_data_valid) hs_n++;
    end
    chk("reached_mid_pkt", 32'(hs_n), 32'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {30'b0, udp_send_data_valid, busy}, 32'd0);
    chk("async_rst_drop1", {14'b0, ovf, drop_cnt1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet(40);
    udp_send_data_ready = 1'b0;
    wr_burst(2'b01, 16'h5550, 16'h0000, int'(P));
    rx_pkt(1'b0, 8'd0, 16'h5550, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
